rtu_rsp_dispatcher: RTL

Producer side of the swcore RTU response interface.
- Accepts lookup results from the single shared RTU engine, one result per cycle, each tagged with its ingress port.
- Queues results per ingress port.
- Presents them to the swcore on per-port valid/ack channels with flattened mask and prio buses.
- Sits between the RTU engine and xswc_core; decouples RTU lookup order from per-port swcore consumption.

---
 rtl/rtu_rsp_pkg.sv | 23 ++
 rtl/rtu_rsp_port_fifo.sv | 63 ++++++
 rtl/rtu_rsp_dispatcher.sv | 87 ++++++++
 3 files changed

// File: rtl/rtu_rsp_pkg.sv
// Shared constants, entry layout and helpers for the RTU response dispatcher.
package rtu_rsp_pkg;

  localparam int unsigned c_num_ports  = 7;
  localparam int unsigned c_prio_width = 3;

  // Entry layout for the default configuration; queues store the same packing flattened.
  typedef struct packed {
    logic [c_num_ports-1:0]  mask;
    logic                    drop;
    logic [c_prio_width-1:0] prio;
  } t_rtu_rsp;

  function automatic int unsigned f_log2_ceil(input int unsigned x);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtu_rsp_port_fifo.sv
// Single-port response queue: circular buffer with occupancy counter and head data out.
module rtu_rsp_port_fifo
  import rtu_rsp_pkg::*;
#(
  parameter int unsigned g_depth = 4,
  parameter int unsigned g_width = 11
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [g_width-1:0] data_i,
  output logic [g_width-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned PtrW = f_log2_ceil(g_depth);

  logic [g_width-1:0] mem_q [g_depth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]      count_q, count_d;
  logic [PtrW-1:0]    last_ptr;
  logic               push_en, pop_en;

  assign full_o  = (count_q == (PtrW+1)'(g_depth));
  assign empty_o = (count_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < g_depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en) mem_q[wr_ptr_q] <= data_i;
    end
  end

  // When empty, keep showing the most recently popped entry so outputs hold.
  assign last_ptr = rd_ptr_q - 1'b1;
  assign data_o   = empty_o ? mem_q[last_ptr] : mem_q[rd_ptr_q];

endmodule

// File: rtl/rtu_rsp_dispatcher.sv
// Queues RTU lookup results per ingress port and presents them on per-port valid/ack channels.
// Optional: define RTU_RSP_MASK_SELF_EN to clear the ingress port's own bit from stored masks.
module rtu_rsp_dispatcher
  import rtu_rsp_pkg::*;
#(
  parameter int unsigned g_num_ports  = c_num_ports,
  parameter int unsigned g_prio_width = c_prio_width,
  parameter int unsigned g_fifo_depth = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic [2:0]                          req_port_i,
  input  logic [g_num_ports-1:0]              req_mask_i,
  input  logic                                req_drop_i,
  input  logic [g_prio_width-1:0]             req_prio_i,
  output logic [g_num_ports-1:0]              rtu_rsp_valid_o,
  input  logic [g_num_ports-1:0]              rtu_rsp_ack_i,
  output logic [g_num_ports*g_num_ports-1:0]  rtu_dst_port_mask_o,
  output logic [g_num_ports-1:0]              rtu_drop_o,
  output logic [g_num_ports*g_prio_width-1:0] rtu_prio_o,
  output logic                                bad_port_o
);

  localparam int unsigned EntryW = g_num_ports + 1 + g_prio_width;

  logic                   port_ok;
  logic                   accept;
  logic [g_num_ports-1:0] full, empty, push, pop;
  logic [g_num_ports-1:0] mask_in;
  logic [EntryW-1:0]      entry_in;
  logic [EntryW-1:0]      head [g_num_ports];
  logic                   bad_port_q, bad_port_d;

  assign port_ok = (32'(req_port_i) < g_num_ports);

  // Out-of-range requests are always accepted so the engine never stalls on them.
  assign req_ready_o = port_ok ? ~full[req_port_i] : 1'b1;
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    mask_in = req_mask_i;
`ifdef RTU_RSP_MASK_SELF_EN
    for (int unsigned i = 0; i < g_num_ports; i++) begin
      if (32'(req_port_i) == i) mask_in[i] = 1'b0;
    end
`endif
  end

  assign entry_in = {mask_in, req_drop_i, req_prio_i};
  assign pop      = rtu_rsp_ack_i & ~empty;

  for (genvar p = 0; p < g_num_ports; p++) begin : g_port
    assign push[p] = accept & port_ok & (32'(req_port_i) == p);

    rtu_rsp_port_fifo #(
      .g_depth (g_fifo_depth),
      .g_width (EntryW)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push[p]),
      .pop_i   (pop[p]),
      .data_i  (entry_in),
      .data_o  (head[p]),
      .full_o  (full[p]),
      .empty_o (empty[p])
    );

    assign rtu_rsp_valid_o[p]                           = ~empty[p];
    assign rtu_dst_port_mask_o[p*g_num_ports +: g_num_ports] =
        head[p][EntryW-1 -: g_num_ports];
    assign rtu_drop_o[p]                                = head[p][g_prio_width];
    assign rtu_prio_o[p*g_prio_width +: g_prio_width]   = head[p][g_prio_width-1:0];
  end

  assign bad_port_d = accept & ~port_ok;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) bad_port_q <= 1'b0;
    else          bad_port_q <= bad_port_d;
  end

  assign bad_port_o = bad_port_q;

endmodule
